// File: rtl/eth_fcs_inserter.sv
// -----------------------------------------------------------------------------
// eth_fcs_inserter
//   Appends the 4-byte Ethernet FCS, delivered on s_axis_tuser with the last
//   input beat, to the end of each frame on a 64-bit AXI4-Stream. FCS bytes go
//   out LSB first (byte0 = fcs[7:0]). If the tail does not fit in the last beat,
//   one extra beat carrying the remaining FCS bytes is emitted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_axis_*              input stream (tdata/tkeep/tvalid/tlast/tuser=FCS, tready out)
//   m_axis_*              output stream, one register stage (tready in)
//   fcs_bypass            1 = pass frame unmodified; sampled on first beat of a frame
//   keep_err              one-cycle pulse: accepted beat had non-contiguous tkeep
//   pkt_count, ext_count  saturating counts of output frames / frames needing an extra beat
// -----------------------------------------------------------------------------
module eth_fcs_inserter #(
   parameter int CNT_W       = 32,
   parameter bit STRICT_KEEP = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      s_axis_tdata,
   input  logic [7:0]       s_axis_tkeep,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   input  logic [31:0]      s_axis_tuser,
   output logic             s_axis_tready,
   output logic [63:0]      m_axis_tdata,
   output logic [7:0]       m_axis_tkeep,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,
   input  logic             fcs_bypass,
   output logic             keep_err,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] ext_count
);

   typedef enum logic {PASS, EXTRA} state_t;

   state_t           state_q, state_d;
   logic             sop_q, sop_d;
   logic             byp_q, byp_d;
   logic [31:0]      fcs_rem_q, fcs_rem_d;
   logic [2:0]       rem_n_q, rem_n_d;
   logic [63:0]      tdata_q, tdata_d;
   logic [7:0]       tkeep_q, tkeep_d;
   logic             tvalid_q, tvalid_d;
   logic             tlast_q, tlast_d;
   logic             keep_err_q, keep_err_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic [CNT_W-1:0] ext_q, ext_d;

   logic        out_free, s_fire, m_fire, bypass_eff, noncontig;
   logic [3:0]  n;
   logic [8:0]  data_keep9, ins_keep9;
   logic [4:0]  ext_keep5;
   logic [63:0] fcs_sh;
   logic [31:0] fcs_hi;

   function automatic logic [63:0] byte_mask(input logic [7:0] k);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   assign out_free      = !tvalid_q || m_axis_tready;
   assign s_axis_tready = (state_q == PASS) && out_free;
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign m_fire        = tvalid_q && m_axis_tready;
   assign bypass_eff    = sop_q ? fcs_bypass : byp_q;
   // x & (x+1) is zero only for 2^k-1 patterns (all-ones wraps to zero)
   assign noncontig     = (s_axis_tkeep & (s_axis_tkeep + 8'd1)) != 8'd0;

   // n = index of highest set keep bit + 1; holes below it are ignored
   always_comb begin
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (s_axis_tkeep[i]) n = 4'(i + 1);
      end
   end

   assign data_keep9 = (9'd1 << n) - 9'd1;
   assign ins_keep9  = (9'd1 << (n + 4'd4)) - 9'd1;
   assign ext_keep5  = (5'd1 << rem_n_q) - 5'd1;
   // FCS placed right after the last data byte; bytes shifted past byte7 drop out
   assign fcs_sh     = {32'd0, s_axis_tuser} << {n, 3'b000};
   // FCS bytes that overflow the last beat, realigned to byte0
   assign fcs_hi     = s_axis_tuser >> {4'd8 - n, 3'b000};

   always_comb begin
      state_d    = state_q;
      sop_d      = sop_q;
      byp_d      = byp_q;
      fcs_rem_d  = fcs_rem_q;
      rem_n_d    = rem_n_q;
      tdata_d    = tdata_q;
      tkeep_d    = tkeep_q;
      tlast_d    = tlast_q;
      tvalid_d   = tvalid_q && !m_axis_tready;
      keep_err_d = 1'b0;
      pkt_d      = pkt_q;
      ext_d      = ext_q;

      if (m_fire && tlast_q && (pkt_q != {CNT_W{1'b1}})) pkt_d = pkt_q + 1'b1;

      case (state_q)
         PASS: begin
            if (s_fire) begin
               sop_d      = s_axis_tlast;
               if (sop_q) byp_d = fcs_bypass;
               keep_err_d = STRICT_KEEP && noncontig;
               tvalid_d   = 1'b1;
               if (!s_axis_tlast || bypass_eff) begin
                  tdata_d = s_axis_tdata & byte_mask(s_axis_tkeep);
                  tkeep_d = s_axis_tkeep;
                  tlast_d = s_axis_tlast;
               end else if (n <= 4'd4) begin
                  tdata_d = (s_axis_tdata & byte_mask(data_keep9[7:0])) | fcs_sh;
                  tkeep_d = ins_keep9[7:0];
                  tlast_d = 1'b1;
               end else begin
                  tdata_d   = (s_axis_tdata & byte_mask(data_keep9[7:0])) | fcs_sh;
                  tkeep_d   = 8'hFF;
                  tlast_d   = 1'b0;
                  fcs_rem_d = fcs_hi;
                  rem_n_d   = 3'(n - 4'd4);
                  state_d   = EXTRA;
                  if (ext_q != {CNT_W{1'b1}}) ext_d = ext_q + 1'b1;
               end
            end
         end
         EXTRA: begin
            if (out_free) begin
               tvalid_d = 1'b1;
               tdata_d  = {32'd0, fcs_rem_q};
               tkeep_d  = {4'd0, ext_keep5[3:0]};
               tlast_d  = 1'b1;
               state_d  = PASS;
            end
         end
         default: state_d = PASS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PASS;
         sop_q      <= 1'b1;
         byp_q      <= 1'b0;
         fcs_rem_q  <= '0;
         rem_n_q    <= '0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         keep_err_q <= 1'b0;
         pkt_q      <= '0;
         ext_q      <= '0;
      end else begin
         state_q    <= state_d;
         sop_q      <= sop_d;
         byp_q      <= byp_d;
         fcs_rem_q  <= fcs_rem_d;
         rem_n_q    <= rem_n_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         keep_err_q <= keep_err_d;
         pkt_q      <= pkt_d;
         ext_q      <= ext_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign keep_err      = keep_err_q;
   assign pkt_count     = pkt_q;
   assign ext_count     = ext_q;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// -----------------------------------------------------------------------------
// tb_eth_fcs_inserter
//   Directed bench for eth_fcs_inserter: frame-level FCS insertion cases,
//   bypass, a randomised stream against a byte-level model, reset during the
//   extra beat, and keep_err on a non-contiguous keep.
// -----------------------------------------------------------------------------
module tb_eth_fcs_inserter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] s_tdata = '0;
   logic [7:0]  s_tkeep = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic [31:0] s_tuser = '0;
   logic        s_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_ready = 1'b1;
   logic        fcs_byp = 1'b0;
   logic        keep_err;
   logic [31:0] pkt_count, ext_count;

   bit          ready_mode = 1'b0;   // 0: m_ready = ready_val, 1: random
   logic        ready_val  = 1'b1;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t outq[$];
   beat_t expq[$];
   int    n_cmp = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   eth_fcs_inserter #(.CNT_W(32), .STRICT_KEEP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_ready),
      .fcs_bypass(fcs_byp), .keep_err(keep_err),
      .pkt_count(pkt_count), .ext_count(ext_count)
   );

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] kmask(input logic [7:0] k);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic logic [63:0] base(input int b);
      return 64'h0706050403020100 + 64'h0808080808080808 * 64'(b);
   endfunction

   always @(posedge clk) begin
      #2;
      m_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
   end

   // output capture plus held-beat stability check
   beat_t prev;
   bit    prev_hold = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 80'(m_tvalid), 80'(1'b1));
            check("hold_beat", 80'({m_tdata, m_tkeep, m_tlast}), 80'(prev));
         end
         if (m_tvalid && m_ready) begin
            outq.push_back({m_tdata, m_tkeep, m_tlast});
            $display("out beat: data=%h keep=%h last=%0d", m_tdata, m_tkeep, m_tlast);
         end
         prev_hold = m_tvalid && !m_ready;
         prev      = {m_tdata, m_tkeep, m_tlast};
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [31:0] u, input logic fb, input int gap);
      int waited;
      repeat (gap) begin @(posedge clk); #1; end
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; fcs_byp = fb; s_tvalid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         waited++;
         if (waited > 500) begin
            n_cmp++; n_err++;
            $error("FAIL send_timeout: observed tready=0 for %0d cycles expected 1", waited);
            break;
         end
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   // byte-level model of the inserted output for one input beat
   task automatic model_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [31:0] u, input logic eff);
      logic [7:0]  b[16];
      logic [63:0] o0, o1;
      int          n;
      if (!l || eff) begin
         expq.push_back({d & kmask(k), k, l});
         return;
      end
      n = 0;
      for (int i = 0; i < 8; i++) if (k[i]) n = i + 1;
      for (int i = 0; i < 16; i++) b[i] = 8'h00;
      for (int i = 0; i < n; i++) b[i] = d[8*i +: 8];
      for (int j = 0; j < 4; j++) b[n+j] = u[8*j +: 8];
      for (int i = 0; i < 8; i++) begin
         o0[8*i +: 8] = b[i];
         o1[8*i +: 8] = b[8+i];
      end
      if (n <= 4) begin
         expq.push_back({o0, 8'((16'd1 << (n + 4)) - 16'd1), 1'b1});
      end else begin
         expq.push_back({o0, 8'hFF, 1'b0});
         expq.push_back({o1, 8'((16'd1 << (n - 4)) - 16'd1), 1'b1});
      end
   endtask

   task automatic drain_compare(input string tag);
      int cnt;
      cnt = expq.size();
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (outq.size() >= cnt) break;
      end
      repeat (3) @(negedge clk);
      check({tag, "_count"}, 80'(outq.size()), 80'(cnt));
      for (int i = 0; i < cnt && i < outq.size(); i++) check(tag, 80'(outq[i]), 80'(expq[i]));
      outq.delete();
      expq.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] d;
      int          len, nb, r;
      logic        fb_first, fb;
      logic [31:0] u;

      // T0: reset state
      #2;
      check("rst_tvalid", 80'(m_tvalid), 80'(1'b0));
      check("rst_tdata", 80'(m_tdata), 80'(64'h0));
      check("rst_tkeep", 80'(m_tkeep), 80'(8'h00));
      check("rst_tlast", 80'(m_tlast), 80'(1'b0));
      check("rst_keep_err", 80'(keep_err), 80'(1'b0));
      check("rst_pkt", 80'(pkt_count), 80'(32'd0));
      check("rst_ext", 80'(ext_count), 80'(32'd0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_tready", 80'(s_tready), 80'(1'b1));

      // T1: 64B frame -> 9 beats, extra beat carries the whole FCS
      for (int b = 0; b < 8; b++) begin
         send_beat(base(b), 8'hFF, b == 7, 32'hDEADBEEF, 1'b0, 0);
         expq.push_back({base(b), 8'hFF, 1'b0});
      end
      expq.push_back({64'h00000000DEADBEEF, 8'h0F, 1'b1});
      drain_compare("t1_beat");
      check("t1_ext", 80'(ext_count), 80'(32'd1));
      check("t1_pkt", 80'(pkt_count), 80'(32'd1));

      // T2: 60B frame, FCS fills the upper half of the last beat
      for (int b = 0; b < 8; b++) begin
         send_beat(base(b), (b == 7) ? 8'h0F : 8'hFF, b == 7, 32'h11223344, 1'b0, 0);
         if (b < 7) expq.push_back({base(b), 8'hFF, 1'b0});
      end
      d = base(7);
      expq.push_back({32'h11223344, d[31:0], 8'hFF, 1'b1});
      drain_compare("t2_beat");
      check("t2_pkt", 80'(pkt_count), 80'(32'd2));

      // T3: 6B frame, FCS split across the last beat and one extra beat
      send_beat(64'hF0E1D2C3B4A59687, 8'h3F, 1'b1, 32'hAABBCCDD, 1'b0, 0);
      check("t3_tready_extra", 80'(s_tready), 80'(1'b0));
      expq.push_back({64'hCCDDD2C3B4A59687, 8'hFF, 1'b0});
      expq.push_back({64'h000000000000AABB, 8'h03, 1'b1});
      drain_compare("t3_beat");
      check("t3_ext", 80'(ext_count), 80'(32'd2));

      // T5: bypass taken from the first beat only; later fcs_bypass=0 ignored
      send_beat(base(0), 8'hFF, 1'b0, 32'h55667788, 1'b1, 0);
      send_beat(base(1), 8'hFF, 1'b0, 32'h55667788, 1'b0, 0);
      send_beat(base(2), 8'h0F, 1'b1, 32'h55667788, 1'b0, 0);
      d = base(2);
      expq.push_back({base(0), 8'hFF, 1'b0});
      expq.push_back({base(1), 8'hFF, 1'b0});
      expq.push_back({32'h0, d[31:0], 8'h0F, 1'b1});
      drain_compare("t5_beat");
      check("t5_pkt", 80'(pkt_count), 80'(32'd4));

      // T4: random frames, random gaps and back-pressure
      ready_mode = 1'b1;
      for (int f = 0; f < 40; f++) begin
         len      = $urandom_range(1, 60);
         nb       = (len + 7) / 8;
         r        = len - 8 * (nb - 1);
         u        = $urandom;
         fb_first = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < nb; b++) begin
            d  = {$urandom, $urandom};
            fb = (b == 0) ? fb_first : 1'($urandom_range(0, 1));
            send_beat(d, (b == nb - 1) ? 8'((16'd1 << r) - 16'd1) : 8'hFF, b == nb - 1,
                      u, fb, $urandom_range(0, 2));
            model_beat(d, (b == nb - 1) ? 8'((16'd1 << r) - 16'd1) : 8'hFF, b == nb - 1,
                       u, fb_first);
         end
      end
      drain_compare("t4_beat");
      check("t4_pkt", 80'(pkt_count), 80'(32'd44));
      ready_mode = 1'b0;
      ready_val  = 1'b1;

      // T6: reset while stalled in the extra-beat state
      ready_val = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      send_beat(base(3), 8'hFF, 1'b1, 32'h12345678, 1'b0, 0);
      @(posedge clk); #1;
      check("t6_stalled_tready", 80'(s_tready), 80'(1'b0));
      check("t6_stalled_tvalid", 80'(m_tvalid), 80'(1'b1));
      rst_n = 1'b0;
      #1;
      check("t6_rst_tvalid", 80'(m_tvalid), 80'(1'b0));
      check("t6_rst_pkt", 80'(pkt_count), 80'(32'd0));
      check("t6_rst_ext", 80'(ext_count), 80'(32'd0));
      @(posedge clk); #1;
      rst_n     = 1'b1;
      ready_val = 1'b1;
      outq.delete();
      repeat (2) begin @(posedge clk); #1; end
      send_beat(64'h1122334455667788, 8'h3F, 1'b1, 32'hA1B2C3D4, 1'b0, 0);
      expq.push_back({64'hC3D4334455667788, 8'hFF, 1'b0});
      expq.push_back({64'h000000000000A1B2, 8'h03, 1'b1});
      drain_compare("t6_fresh");
      // keep 05 on a last beat: n=3, FCS at bytes 3..6, one-cycle keep_err
      send_beat(64'h0000000000CC00AA, 8'h05, 1'b1, 32'h99887766, 1'b0, 0);
      check("t6_keep_err_pulse", 80'(keep_err), 80'(1'b1));
      @(posedge clk); #1;
      check("t6_keep_err_clear", 80'(keep_err), 80'(1'b0));
      expq.push_back({64'h0099887766CC00AA, 8'h7F, 1'b1});
      drain_compare("t6_keep05");
      check("t6_pkt", 80'(pkt_count), 80'(32'd2));
      check("t6_ext", 80'(ext_count), 80'(32'd1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
